// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types and constants for the 7-segment scan path
// Purpose: scan FSM state encoding, segment bit positions, hex->segment table.
// Ports: none (package).
package seven_seg_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_DWELL
  } scan_state_e;

  // Segment byte layout is {dp,g,f,e,d,c,b,a}
  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high g..a patterns, indexed by nibble value
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/display_scan_sequencer_if.sv
// rtl/display_scan_sequencer_if.sv - frame handshake bundle between producer and sequencer
// Purpose: groups the valid/ready frame transfer signals.
// Ports: frame_valid, frame_ready, frame_data[15:0] (digit0 = [3:0]), frame_dp[3:0].
interface display_scan_sequencer_if;

  logic        frame_valid;
  logic        frame_ready;
  logic [15:0] frame_data;
  logic [3:0]  frame_dp;

  modport master (
    output frame_valid,
    output frame_data,
    output frame_dp,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  frame_data,
    input  frame_dp,
    output frame_ready
  );

endinterface

// File: rtl/display_scan_sequencer_seg_decoder.sv
// rtl/display_scan_sequencer_seg_decoder.sv - combinational nibble+dp to segment byte
// Purpose: maps one hex digit and its decimal point to {dp,g,f,e,d,c,b,a}.
// Ports: nibble[3:0] in, dp in, seg[7:0] out.
module seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg              = '0;
    seg[SEG_G:SEG_A] = HEX_SEG[nibble];
    seg[SEG_DP]      = dp;
  end

endmodule

// File: rtl/display_scan_sequencer.sv
// rtl/display_scan_sequencer.sv - double-buffered 4-digit serial 7-segment scanner
// Purpose: accepts hex frames, scans digits: decode, shift out MSB first,
//   latch, then drive the digit cathode for a dwell with PWM brightness.
// Ports: sysclk, rst (sync, active high), frame_bus (slave handshake),
//   bright[3:0] in; cath[3:0], shift, data, latch, blank out.
module display_scan_sequencer
  import seven_seg_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DWELL   = 100000
) (
  input  logic                           sysclk,
  input  logic                           rst,
  display_scan_sequencer_if.slave        frame_bus,
  input  logic [3:0]                     bright,
  output logic [3:0]                     cath,
  output logic                           shift,
  output logic                           data,
  output logic                           latch,
  output logic                           blank
);

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int DW_W  = $clog2(DWELL);
  localparam int SLICE = DWELL / 16;

  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] BIT_LAST   = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);

  scan_state_e      state_q, state_d;
  logic [19:0]      active_q, pending_q;
  logic             pend_q;
  logic [1:0]       idx_q;
  logic [2:0]       bit_q;
  logic [DIV_W-1:0] div_q;
  logic [DW_W-1:0]  dwell_q;
  logic [7:0]       seg_q;
  logic [3:0]       bright_q;

  logic        accept;
  logic        take_pending;
  logic [19:0] load_frame;
  logic [7:0]  seg_next;
  logic [31:0] on_time;

  assign frame_bus.frame_ready = !pend_q;
  assign accept       = frame_bus.frame_valid && !pend_q;
  // Frames switch only at the digit-0 load so one scan never mixes two frames
  assign take_pending = (state_q == ST_LOAD) && (idx_q == 2'd0) && pend_q;
  assign load_frame   = take_pending ? pending_q : active_q;
  assign on_time      = (32'(bright_q) + 32'd1) * 32'(SLICE);

  seg_decoder u_dec (
    .nibble (load_frame[{idx_q, 2'b00} +: 4]),
    .dp     (load_frame[5'd16 + 5'(idx_q)]),
    .seg    (seg_next)
  );

  always_ff @(posedge sysclk) begin
    if (rst) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cath    = 4'b0000;
    shift   = 1'b0;
    data    = 1'b0;
    latch   = 1'b0;
    blank   = 1'b1;
    case (state_q)
      ST_LOAD: state_d = ST_SHIFT;
      ST_SHIFT: begin
        // Low half holds the bit, high half clocks it; data only moves with shift low
        shift = (div_q >= DIV_HALF);
        data  = seg_q[bit_q];
        if (div_q == BIT_LAST && bit_q == 3'd0) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        latch = 1'b1;
        if (div_q == LATCH_LAST) state_d = ST_DWELL;
      end
      ST_DWELL: begin
        cath  = 4'b0001 << idx_q;
        blank = !(32'(dwell_q) < on_time);
        if (dwell_q == DWELL_LAST) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      active_q  <= '0;
      pending_q <= '0;
      pend_q    <= 1'b0;
      idx_q     <= 2'd0;
      bit_q     <= 3'd7;
      div_q     <= '0;
      dwell_q   <= '0;
      seg_q     <= '0;
      bright_q  <= '0;
    end else begin
      // An accept in the same cycle as a copy keeps pending set with the new frame
      if (accept) begin
        pending_q <= {frame_bus.frame_dp, frame_bus.frame_data};
        pend_q    <= 1'b1;
      end else if (take_pending) begin
        pend_q    <= 1'b0;
      end

      case (state_q)
        ST_LOAD: begin
          if (take_pending) active_q <= pending_q;
          seg_q    <= seg_next;
          bright_q <= bright;
          bit_q    <= 3'd7;
          div_q    <= '0;
        end
        ST_SHIFT: begin
          if (div_q == BIT_LAST) begin
            div_q <= '0;
            if (bit_q != 3'd0) bit_q <= bit_q - 3'd1;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        ST_LATCH: begin
          if (div_q == LATCH_LAST) begin
            div_q   <= '0;
            dwell_q <= '0;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        ST_DWELL: begin
          if (dwell_q == DWELL_LAST) begin
            dwell_q <= '0;
            idx_q   <= idx_q + 2'd1;
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_sequencer.sv
// tb/tb_display_scan_sequencer.sv - directed self-checking bench for display_scan_sequencer
module tb_display_scan_sequencer;

  logic       sysclk = 1'b0;
  logic       rst    = 1'b1;
  logic [3:0] bright = 4'hF;
  logic [3:0] cath;
  logic       shift, data, latch, blank;

  display_scan_sequencer_if fb ();

  display_scan_sequencer #(.CLK_DIV(2), .DWELL(32)) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .frame_bus (fb),
    .bright    (bright),
    .cath      (cath),
    .shift     (shift),
    .data      (data),
    .latch     (latch),
    .blank     (blank)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  // Output monitor: rebuilds shifted bytes, latch timing and dwell statistics
  int         cyc = 0;
  logic [7:0] sr = 8'h00;
  logic       prev_shift = 1'b0, prev_data = 1'b0, prev_latch = 1'b0, prev_ready = 1'b1;
  logic [3:0] prev_cath = 4'b0000;
  int         lat_len = 0, dw_len = 0, dw_on = 0, dw_lead = 0;
  logic       seen_high = 1'b0;
  int         data_err = 0, ghost_err = 0;
  int         ready_rise_t = -1;
  logic [7:0] byte_q [$];
  int         latch_t [$];
  int         latlen_q [$];
  logic [3:0] cath_q [$];
  int         dwlen_q [$];
  int         on_q [$];
  int         lead_q [$];

  always @(negedge sysclk) begin
    cyc++;
    if (shift && !prev_shift) sr = {sr[6:0], data};
    if (shift && prev_shift && data !== prev_data) data_err++;
    if (cath != 4'b0000 && (shift || latch)) ghost_err++;
    if (latch && !prev_latch) begin
      byte_q.push_back(sr);
      latch_t.push_back(cyc);
      lat_len = 0;
    end
    if (latch) lat_len++;
    if (!latch && prev_latch) latlen_q.push_back(lat_len);
    if (cath != 4'b0000) begin
      if (prev_cath == 4'b0000) begin
        dw_len = 0; dw_on = 0; dw_lead = 0; seen_high = 1'b0;
      end
      dw_len++;
      if (!blank) dw_on++;
      if (blank) seen_high = 1'b1;
      else if (!seen_high) dw_lead++;
    end
    if (cath == 4'b0000 && prev_cath != 4'b0000) begin
      cath_q.push_back(prev_cath);
      dwlen_q.push_back(dw_len);
      on_q.push_back(dw_on);
      lead_q.push_back(dw_lead);
    end
    if (fb.frame_ready && !prev_ready) ready_rise_t = cyc;
    prev_shift = shift;
    prev_data  = data;
    prev_latch = latch;
    prev_cath  = cath;
    prev_ready = fb.frame_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge sysclk);
      #1;
    end
  endtask

  task automatic wait_bytes(input int n, input int budget, input string tag);
    int k = 0;
    while (byte_q.size() < n && k < budget) begin tick(); k++; end
    chk(tag, 32'(byte_q.size() >= n), 32'd1);
  endtask

  task automatic wait_dwells(input int n, input int budget, input string tag);
    int k = 0;
    while (cath_q.size() < n && k < budget) begin tick(); k++; end
    chk(tag, 32'(cath_q.size() >= n), 32'd1);
  endtask

  task automatic clear_mon();
    byte_q.delete(); latch_t.delete(); latlen_q.delete();
    cath_q.delete(); dwlen_q.delete(); on_q.delete(); lead_q.delete();
  endtask

  int rel;
  int k;

  initial begin
    fb.frame_valid = 1'b0;
    fb.frame_data  = 16'h0000;
    fb.frame_dp    = 4'b0000;

    // Reset state
    rst = 1'b1;
    tick(2);
    chk("rst_outs", {cath, shift, data, latch, blank, fb.frame_ready}, 9'b0000_0_0_0_1_1);
    rel = cyc;
    rst = 1'b0;
    clear_mon();

    // Free run on the all-zero active frame
    wait_bytes(5, 800, "b_bytes_timeout");
    wait_dwells(5, 800, "b_dwell_timeout");
    chk("b_first_latch", 32'(latch_t[0] - rel), 32'd33);
    for (int i = 0; i < 5; i++) begin
      chk("b_byte", 32'(byte_q[i]), 32'h3F);
      chk("b_latch_len", 32'(latlen_q[i]), 32'd2);
      chk("b_dwell_len", 32'(dwlen_q[i]), 32'd32);
      chk("b_dwell_on", 32'(on_q[i]), 32'd32);
    end
    chk("b_cath0", 32'(cath_q[0]), 32'h1);
    chk("b_cath1", 32'(cath_q[1]), 32'h2);
    chk("b_cath2", 32'(cath_q[2]), 32'h4);
    chk("b_cath3", 32'(cath_q[3]), 32'h8);
    chk("b_cath4", 32'(cath_q[4]), 32'h1);
    for (int i = 0; i < 4; i++) chk("b_period", 32'(latch_t[i+1] - latch_t[i]), 32'd67);

    // Frame 0x1234 sent during digit 1 dwell
    k = 0;
    while (cath !== 4'b0010 && k < 400) begin tick(); k++; end
    chk("c_reach_digit1", 32'(cath), 32'h2);
    fb.frame_data  = 16'h1234;
    fb.frame_dp    = 4'b0000;
    fb.frame_valid = 1'b1;
    tick();
    chk("c_ready_fall", 32'(fb.frame_ready), 32'd0);
    fb.frame_valid = 1'b0;
    clear_mon();
    ready_rise_t = -1;
    wait_bytes(6, 800, "c_bytes_timeout");
    chk("c_old_d2", 32'(byte_q[0]), 32'h3F);
    chk("c_old_d3", 32'(byte_q[1]), 32'h3F);
    chk("c_new_d0", 32'(byte_q[2]), 32'h66);
    chk("c_new_d1", 32'(byte_q[3]), 32'h4F);
    chk("c_new_d2", 32'(byte_q[4]), 32'h5B);
    chk("c_new_d3", 32'(byte_q[5]), 32'h06);
    chk("c_ready_rise", 32'(latch_t[2] - ready_rise_t), 32'd32);

    // Brightness 7 then 15
    bright = 4'd7;
    clear_mon();
    wait_dwells(2, 400, "d7_timeout");
    chk("d7_len", 32'(dwlen_q[1]), 32'd32);
    chk("d7_on", 32'(on_q[1]), 32'd16);
    chk("d7_lead", 32'(lead_q[1]), 32'd16);
    bright = 4'd15;
    clear_mon();
    wait_dwells(2, 400, "d15_timeout");
    chk("d15_on", 32'(on_q[1]), 32'd32);
    chk("d15_lead", 32'(lead_q[1]), 32'd32);

    // Back-to-back frames: 0xFEDC dp=0100, then 0x4A0E held while ready is low
    fb.frame_data  = 16'hFEDC;
    fb.frame_dp    = 4'b0100;
    fb.frame_valid = 1'b1;
    tick();
    chk("e_ready_fall", 32'(fb.frame_ready), 32'd0);
    fb.frame_data = 16'h4A0E;
    fb.frame_dp   = 4'b0000;
    ready_rise_t  = -1;
    k = 0;
    while (!fb.frame_ready && k < 400) begin tick(); k++; end
    chk("e_ready_rise", 32'(fb.frame_ready), 32'd1);
    clear_mon();
    rel = ready_rise_t;
    tick();
    chk("e_second_accept", 32'(fb.frame_ready), 32'd0);
    fb.frame_valid = 1'b0;
    wait_bytes(8, 800, "e_bytes_timeout");
    chk("e_rise_vs_latch", 32'(latch_t[0] - rel), 32'd32);
    chk("e_f1_d0", 32'(byte_q[0]), 32'h39);
    chk("e_f1_d1", 32'(byte_q[1]), 32'h5E);
    chk("e_f1_d2", 32'(byte_q[2]), 32'hF9);
    chk("e_f1_d3", 32'(byte_q[3]), 32'h71);
    chk("e_f2_d0", 32'(byte_q[4]), 32'h79);
    chk("e_f2_d1", 32'(byte_q[5]), 32'h3F);
    chk("e_f2_d2", 32'(byte_q[6]), 32'h77);
    chk("e_f2_d3", 32'(byte_q[7]), 32'h66);
    chk("e_ready_end", 32'(fb.frame_ready), 32'd1);

    // Reset mid-shift with a frame pending
    fb.frame_data  = 16'h8888;
    fb.frame_dp    = 4'b1111;
    fb.frame_valid = 1'b1;
    tick();
    chk("f_pending", 32'(fb.frame_ready), 32'd0);
    fb.frame_valid = 1'b0;
    k = 0;
    while (!shift && k < 200) begin tick(); k++; end
    chk("f_in_shift", 32'(shift), 32'd1);
    rst = 1'b1;
    tick();
    chk("f_rst_outs", {cath, shift, data, latch, blank, fb.frame_ready}, 9'b0000_0_0_0_1_1);
    rel = cyc;
    rst = 1'b0;
    clear_mon();
    wait_bytes(1, 200, "f_bytes_timeout");
    wait_dwells(1, 200, "f_dwell_timeout");
    chk("f_byte", 32'(byte_q[0]), 32'h3F);
    chk("f_cath", 32'(cath_q[0]), 32'h1);
    chk("f_first_latch", 32'(latch_t[0] - rel), 32'd33);
    chk("f_ready", 32'(fb.frame_ready), 32'd1);

    chk("data_stable", 32'(data_err), 32'd0);
    chk("no_ghost", 32'(ghost_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_sequencer.md
# display_scan_sequencer

Sequences the serial 7-segment display path: accepts a 4-digit hex frame over a valid/ready handshake and double-buffers it. It scans the four digits in turn. Per digit it decodes the nibble, shifts the 8-bit segment pattern out to the external shift register, pulses latch, then enables the digit's cathode for a programmable dwell with PWM brightness. It sits between the digit producers (e.g. counter) and the display pins, replacing the separate refresh/cathode/anode/shift logic with one scheduler.

## Interface
- CLK_DIV, 2: sysclk cycles per shift-clock half-period; must be ≥1.
- DWELL, 100000: sysclk cycles a digit is displayed; must be a multiple of 16 and ≥16.
- sysclk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_valid  in  1  producer has a frame on frame_data/frame_dp.
- frame_ready  out  1  sequencer can accept a frame.
- frame_data  in  16  digit3..digit0 nibbles; digit0 = [3:0].
- frame_dp  in  4  decimal point per digit; bit n = digit n.
- bright  in  4  brightness; sampled at each LOAD.
- cath  out  4  one-hot, active-high digit enable; bit n = digit n.
- shift  out  1  shift-register clock.
- data  out  1  serial segment data, MSB first.
- latch  out  1  storage-register latch pulse.
- blank  out  1  active-high output disable.

## Operation
- Segment byte = {dp,g,f,e,d,c,b,a}, active high. Standard hex decode: 0→0x3F, 1→0x06, 4→0x66, A→0x77, E→0x79, F→0x71.
- Registers: active frame (20 b), pending frame (20 b) with pending flag, digit index (2 b), state, bit counter (3 b), divider counter, dwell counter.
- frame_ready = !pending. When frame_valid && frame_ready, the frame is copied to pending and pending is set.
- FSM states and transitions:
  - LOAD (1 cycle): if digit index = 0 and pending, copy pending→active and clear pending. Decode the active digit into the shift byte. Sample bright. cath=0, blank=1. Next state SHIFT.
  - SHIFT: 8 bits, MSB first. Per bit, data holds the bit with shift=0 for CLK_DIV cycles, then shift=1 for CLK_DIV cycles. After bit 0 completes, next state LATCH.
  - LATCH: latch=1, shift=0 for CLK_DIV cycles. Next state DWELL.
  - DWELL: cath = one-hot(index). blank = 0 while dwell_cnt < (bright+1)·(DWELL/16), else 1. After DWELL cycles, index = index+1 (wraps 3→0), then LOAD.
- During LOAD/SHIFT/LATCH, cath=0 and blank=1, so ghosting is impossible.
- Simultaneous accept and LOAD-copy in one cycle: the old pending frame goes to active; the incoming frame becomes the new pending, so pending stays set.
- A new frame only takes effect at a digit-0 LOAD, so a scan never mixes two frames.
- bright = 15 gives full on-time (blank never high in DWELL).

## Timing
- Reset values:
  - Outputs: cath=0, shift=0, data=0, latch=0, blank=1, frame_ready=1.
  - Internal: active frame = 0 (dp = 0), pending cleared, index = 0.
  - First state after reset is LOAD.
- Reset asserted in any state forces these values on the next edge and discards any pending frame.
- Per-digit period = 1 + 17·CLK_DIV + DWELL cycles. Frame period = 4× that.
- data changes only on the cycle shift falls (or at SHIFT entry), never while shift=1.
- frame_ready falls the cycle after accept. It rises the cycle after the digit-0 LOAD that consumes the pending frame.

## Structure
- Package seven_seg_pkg:
  - state enum (LOAD, SHIFT, LATCH, DWELL);
  - segment bit-position constants;
  - 16-entry hex→segment constant table.
- Sub-module seg_decoder: combinational nibble+dp → 8-bit pattern.
- The remainder stays in one sequential module, roughly 200 lines.

## Test plan
All scenarios use CLK_DIV=2, DWELL=32.
- Reset then free-run:
  - digit0 shifts 0x3F (bits 0,0,1,1,1,1,1,1), then latch high for 2 cycles, then cath=0001 for 32 cycles;
  - per-digit period is 67 cycles; cath sequence 0001→0010→0100→1000→0001.
- Send frame 0x1234, dp=0000 mid-scan:
  - frame_ready low until the next digit-0 LOAD;
  - that scan shifts 0x66, 0x4F, 0x5B, 0x06.
- bright=7 in DWELL: blank low for 16 cycles, then high for 16; bright=15: blank low all 32.
- Back-to-back frames:
  - second valid held while ready=0 and accepted only after the digit-0 LOAD;
  - simultaneous accept+copy case leaves the new frame pending with ready=0.
- Frame 0xFEDC, dp=0100 → digit2 (E) shifts 0xF9 and digit3 (F) shifts 0x71.
- rst pulsed mid-SHIFT: outputs take reset values the next cycle, pending cleared; scan restarts at digit0 showing 0x3F.
